// File: rtl/mult_issue_queue.sv
// Collapsing reservation station for the pipelined multiplier. Entry 0 is the
// oldest entry. Each cycle the oldest entry whose two operands are ready is issued.
module mult_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             dispatch_en,
  input  logic [2:0]       dispatch_funct3,
  input  logic [TAG_W-1:0] dispatch_rd_tag,
  input  logic             dispatch_rs1_rdy,
  input  logic             dispatch_rs2_rdy,
  input  logic [31:0]      dispatch_rs1_data,
  input  logic [31:0]      dispatch_rs2_data,
  input  logic [TAG_W-1:0] dispatch_rs1_tag,
  input  logic [TAG_W-1:0] dispatch_rs2_tag,
  output logic             queue_full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  input  logic             issue_allow,
  output logic             queue_en,
  output logic [31:0]      op1,
  output logic [31:0]      op2,
  output logic [2:0]       funct3,
  output logic [TAG_W-1:0] tag_in,
  output logic             tag_in_valid,
  output logic [CNT_W-1:0] occupancy
);

  typedef struct packed {
    logic [2:0]       funct3;
    logic [TAG_W-1:0] rd_tag;
    logic             rs1_rdy;
    logic [TAG_W-1:0] rs1_tag;
    logic [31:0]      rs1_data;
    logic             rs2_rdy;
    logic [TAG_W-1:0] rs2_tag;
    logic [31:0]      rs2_data;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           cap   [DEPTH];
  entry_t           ent_n [DEPTH];
  entry_t           new_ent;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_n;
  logic [CNT_W-1:0] cnt_after;
  logic             found;
  logic [IDX_W-1:0] sel;
  logic             dispatch_ok;

  // Only the entries below count_q are valid. The slots above it hold stale data.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && (CNT_W'(i) < count_q) && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
        found = 1'b1;
        sel   = IDX_W'(i);
      end
    end
  end

  assign queue_en     = issue_allow & found & ~flush;
  assign tag_in_valid = queue_en;
  assign op1          = queue_en ? ent_q[sel].rs1_data : '0;
  assign op2          = queue_en ? ent_q[sel].rs2_data : '0;
  assign funct3       = queue_en ? ent_q[sel].funct3   : '0;
  assign tag_in       = queue_en ? ent_q[sel].rd_tag   : '0;
  assign queue_full   = (count_q == CNT_W'(DEPTH));
  assign occupancy    = count_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cap[i] = ent_q[i];
      if (cdb_valid && !cap[i].rs1_rdy && (cap[i].rs1_tag == cdb_tag)) begin
        cap[i].rs1_rdy  = 1'b1;
        cap[i].rs1_data = cdb_data;
      end
      if (cdb_valid && !cap[i].rs2_rdy && (cap[i].rs2_tag == cdb_tag)) begin
        cap[i].rs2_rdy  = 1'b1;
        cap[i].rs2_data = cdb_data;
      end
    end
  end

  // A new micro-op can take an operand from the CDB in the same cycle that it is dispatched.
  always_comb begin
    new_ent.funct3   = dispatch_funct3;
    new_ent.rd_tag   = dispatch_rd_tag;
    new_ent.rs1_rdy  = dispatch_rs1_rdy;
    new_ent.rs1_tag  = dispatch_rs1_tag;
    new_ent.rs1_data = dispatch_rs1_data;
    new_ent.rs2_rdy  = dispatch_rs2_rdy;
    new_ent.rs2_tag  = dispatch_rs2_tag;
    new_ent.rs2_data = dispatch_rs2_data;
    if (!dispatch_rs1_rdy && cdb_valid && (dispatch_rs1_tag == cdb_tag)) begin
      new_ent.rs1_rdy  = 1'b1;
      new_ent.rs1_data = cdb_data;
    end
    if (!dispatch_rs2_rdy && cdb_valid && (dispatch_rs2_tag == cdb_tag)) begin
      new_ent.rs2_rdy  = 1'b1;
      new_ent.rs2_data = cdb_data;
    end
  end

  always_comb begin
    dispatch_ok = dispatch_en & ~queue_full;
    cnt_after   = count_q - CNT_W'(queue_en);
    for (int i = 0; i < DEPTH; i++) begin
      ent_n[i] = cap[i];
    end
    if (queue_en) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IDX_W'(i) >= sel) begin
          ent_n[i] = cap[i+1];
        end
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (dispatch_ok && (CNT_W'(i) == cnt_after)) begin
        ent_n[i] = new_ent;
      end
    end
    count_n = flush ? '0 : cnt_after + CNT_W'(dispatch_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      count_q <= count_n;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_n[i];
      end
    end
  end

endmodule

// File: tb/tb_mult_issue_queue.sv
// Bench for mult_issue_queue. It runs directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based reference model.
module tb_mult_issue_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 6;

  logic             clk = 1'b0;
  logic             rst, flush, dispatch_en;
  logic [2:0]       dispatch_funct3;
  logic [TAG_W-1:0] dispatch_rd_tag, dispatch_rs1_tag, dispatch_rs2_tag;
  logic             dispatch_rs1_rdy, dispatch_rs2_rdy;
  logic [31:0]      dispatch_rs1_data, dispatch_rs2_data;
  logic             queue_full;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             issue_allow;
  logic             queue_en, tag_in_valid;
  logic [31:0]      op1, op2;
  logic [2:0]       funct3;
  logic [TAG_W-1:0] tag_in;
  logic [2:0]       occupancy;

  int total = 0;
  int bad   = 0;

  mult_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .dispatch_en(dispatch_en),
    .dispatch_funct3(dispatch_funct3), .dispatch_rd_tag(dispatch_rd_tag),
    .dispatch_rs1_rdy(dispatch_rs1_rdy), .dispatch_rs2_rdy(dispatch_rs2_rdy),
    .dispatch_rs1_data(dispatch_rs1_data), .dispatch_rs2_data(dispatch_rs2_data),
    .dispatch_rs1_tag(dispatch_rs1_tag), .dispatch_rs2_tag(dispatch_rs2_tag),
    .queue_full(queue_full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .issue_allow(issue_allow), .queue_en(queue_en),
    .op1(op1), .op2(op2), .funct3(funct3), .tag_in(tag_in),
    .tag_in_valid(tag_in_valid), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       f3;
    logic [TAG_W-1:0] rd;
    bit               r1;
    logic [TAG_W-1:0] t1;
    logic [31:0]      d1;
    bit               r2;
    logic [TAG_W-1:0] t2;
    logic [31:0]      d2;
  } uop_t;

  uop_t model[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr();
    rst = 1'b0; flush = 1'b0; dispatch_en = 1'b0; dispatch_funct3 = '0;
    dispatch_rd_tag = '0; dispatch_rs1_rdy = 1'b0; dispatch_rs2_rdy = 1'b0;
    dispatch_rs1_data = '0; dispatch_rs2_data = '0; dispatch_rs1_tag = '0;
    dispatch_rs2_tag = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic disp(input logic [TAG_W-1:0] rd, input logic [2:0] f3,
                      input bit r1, input logic [31:0] d1, input logic [TAG_W-1:0] t1,
                      input bit r2, input logic [31:0] d2, input logic [TAG_W-1:0] t2);
    dispatch_en = 1'b1; dispatch_rd_tag = rd; dispatch_funct3 = f3;
    dispatch_rs1_rdy = r1; dispatch_rs1_data = d1; dispatch_rs1_tag = t1;
    dispatch_rs2_rdy = r2; dispatch_rs2_data = d2; dispatch_rs2_tag = t2;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] t, input logic [31:0] d);
    cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
  endtask

  // Lets the combinational outputs settle before any literal check is made.
  task automatic settle();
    #2;
  endtask

  // Compares the outputs against the model, advances the model and clocks the DUT.
  // On return the time is 1 ns after the rising edge, so new inputs can be driven.
  task automatic run_cycle();
    int   idx;
    bit   en;
    uop_t u;
    #2;
    idx = -1;
    for (int i = 0; i < model.size(); i++)
      if (idx < 0 && model[i].r1 && model[i].r2) idx = i;
    en = issue_allow && (idx >= 0) && !flush;
    chk("queue_en", {31'd0, queue_en}, {31'd0, en});
    chk("tag_in_valid", {31'd0, tag_in_valid}, {31'd0, en});
    chk("op1", op1, en ? model[idx].d1 : 32'd0);
    chk("op2", op2, en ? model[idx].d2 : 32'd0);
    chk("funct3", {29'd0, funct3}, en ? {29'd0, model[idx].f3} : 32'd0);
    chk("tag_in", {26'd0, tag_in}, en ? {26'd0, model[idx].rd} : 32'd0);
    chk("queue_full", {31'd0, queue_full}, {31'd0, model.size() == DEPTH});
    chk("occupancy", {29'd0, occupancy}, model.size());

    if (rst || flush) begin
      model.delete();
    end else begin
      bit was_full = (model.size() == DEPTH);
      for (int i = 0; i < model.size(); i++) begin
        if (cdb_valid && !model[i].r1 && model[i].t1 == cdb_tag) begin
          model[i].r1 = 1; model[i].d1 = cdb_data;
        end
        if (cdb_valid && !model[i].r2 && model[i].t2 == cdb_tag) begin
          model[i].r2 = 1; model[i].d2 = cdb_data;
        end
      end
      if (en) model.delete(idx);
      if (dispatch_en && !was_full) begin
        u.f3 = dispatch_funct3; u.rd = dispatch_rd_tag;
        u.r1 = dispatch_rs1_rdy; u.t1 = dispatch_rs1_tag; u.d1 = dispatch_rs1_data;
        u.r2 = dispatch_rs2_rdy; u.t2 = dispatch_rs2_tag; u.d2 = dispatch_rs2_data;
        if (!u.r1 && cdb_valid && u.t1 == cdb_tag) begin u.r1 = 1; u.d1 = cdb_data; end
        if (!u.r2 && cdb_valid && u.t2 == cdb_tag) begin u.r2 = 1; u.d2 = cdb_data; end
        model.push_back(u);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    issue_allow = 1'b0;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // The queue is empty after reset.
    issue_allow = 1'b1; settle();
    chk("rst_occ", {29'd0, occupancy}, 0);
    chk("rst_full", {31'd0, queue_full}, 0);
    chk("rst_en", {31'd0, queue_en}, 0);
    run_cycle();

    // A micro-op with both operands ready issues in the cycle after dispatch.
    disp(5, 0, 1, 7, 0, 1, 6, 0); run_cycle();
    clr(); settle();
    chk("rd_en", {31'd0, queue_en}, 1);
    chk("rd_op1", op1, 7);
    chk("rd_op2", op2, 6);
    chk("rd_tag", {26'd0, tag_in}, 5);
    run_cycle();

    // rs1 waits on tag 9. The CDB delivers tag 9 in cycle 3, so the issue happens in cycle 4.
    disp(12, 1, 0, 0, 9, 1, 3, 0); run_cycle();
    clr(); run_cycle(); run_cycle();
    cdb(9, 32'h10); settle();
    chk("wk_no_bypass", {31'd0, queue_en}, 0);
    run_cycle();
    clr(); settle();
    chk("wk_en", {31'd0, queue_en}, 1);
    chk("wk_op1", op1, 32'h10);
    chk("wk_op2", op2, 3);
    run_cycle();

    // The CDB matches tag 9 in the same cycle as the dispatch, so the operand is taken directly.
    disp(13, 0, 0, 0, 9, 1, 4, 0); cdb(9, 32'h20); run_cycle();
    clr(); settle();
    chk("bp_en", {31'd0, queue_en}, 1);
    chk("bp_op1", op1, 32'h20);
    run_cycle();

    // Age order: A waits on tag 11, B and C are ready. The issue order is B, then A, then C.
    issue_allow = 1'b0;
    disp(1, 0, 0, 0, 11, 1, 2, 0); run_cycle();
    disp(2, 0, 1, 3, 0, 1, 4, 0); run_cycle();
    disp(3, 0, 1, 5, 0, 1, 6, 0); run_cycle();
    clr(); issue_allow = 1'b1; cdb(11, 32'h77); settle();
    chk("age_b", {26'd0, tag_in}, 2);
    run_cycle();
    clr(); settle();
    chk("age_a", {26'd0, tag_in}, 1);
    chk("age_a_op1", op1, 32'h77);
    run_cycle();
    settle();
    chk("age_c", {26'd0, tag_in}, 3);
    run_cycle();

    // Fill the queue while issue is held off. A dispatch while full is dropped, even if an issue happens in the same cycle.
    issue_allow = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      disp(TAG_W'(20 + i), 0, 1, i + 1, 0, 1, 2, 0); run_cycle();
    end
    clr(); settle();
    chk("full_flag", {31'd0, queue_full}, 1);
    chk("full_occ", {29'd0, occupancy}, 4);
    disp(30, 0, 1, 9, 0, 1, 9, 0); issue_allow = 1'b1; settle();
    chk("full_issue", {26'd0, tag_in}, 20);
    run_cycle();
    clr(); settle();
    chk("full_occ3", {29'd0, occupancy}, 3);
    for (int i = 1; i < DEPTH; i++) begin
      settle();
      chk("full_drain", {26'd0, tag_in}, 20 + i);
      run_cycle();
    end
    settle();
    chk("full_empty", {31'd0, queue_en}, 0);
    run_cycle();

    // A flush clears all entries. The dispatch and CDB match in the same cycle are discarded.
    issue_allow = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(TAG_W'(40 + i), 0, 0, 0, 50, 1, 1, 0); run_cycle();
    end
    clr(); flush = 1'b1; disp(44, 0, 1, 1, 0, 1, 1, 0); cdb(50, 32'h55); run_cycle();
    clr(); issue_allow = 1'b1; settle();
    chk("fl_occ", {29'd0, occupancy}, 0);
    chk("fl_en", {31'd0, queue_en}, 0);
    run_cycle(); run_cycle();

    // Reset in the middle of operation, with entries pending.
    issue_allow = 1'b0;
    disp(60, 0, 1, 1, 0, 1, 1, 0); run_cycle();
    disp(61, 0, 1, 2, 0, 1, 2, 0); run_cycle();
    clr(); rst = 1'b1; issue_allow = 1'b1; run_cycle();
    clr(); settle();
    chk("rm_occ", {29'd0, occupancy}, 0);
    chk("rm_en", {31'd0, queue_en}, 0);
    chk("rm_valid", {31'd0, tag_in_valid}, 0);
    chk("rm_op1", op1, 0);
    run_cycle();

    // Randomized traffic. Small tag values are used so that CDB matches happen often.
    for (int c = 0; c < 3000; c++) begin
      clr();
      rst         = ($urandom_range(199) == 0);
      flush       = ($urandom_range(49) == 0);
      issue_allow = ($urandom_range(9) < 7);
      if ($urandom_range(9) < 6)
        disp(TAG_W'($urandom_range(63)), 3'($urandom_range(7)),
             $urandom_range(1) == 1, $urandom, TAG_W'($urandom_range(7)),
             $urandom_range(1) == 1, $urandom, TAG_W'($urandom_range(7)));
      if ($urandom_range(1) == 1) cdb(TAG_W'($urandom_range(7)), $urandom);
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_issue_queue.md
# mult_issue_queue

Reservation station and issue scheduler for the 3-stage pipelined multiply unit. Accepts multiply micro-ops from dispatch and holds them until both source operands are available. Operands arrive either at dispatch or by snooping the common data bus (CDB). Each cycle it issues the oldest ready entry into the multiplier, driving its `queue_en`/`op1`/`op2`/`funct3`/`tag_in`/`tag_in_valid` inputs.

## Interface

Parameters:
- `DEPTH`, 4: number of entries (2..8).
- `TAG_W`, 6: ROB/physical tag width; must match multiplier tag width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  pipeline flush (mispredict); clears all entries.
- `dispatch_en`  in  1  write a new micro-op this cycle.
- `dispatch_funct3`  in  3  multiply variant (0 = low word, else high word).
- `dispatch_rd_tag`  in  TAG_W  destination tag.
- `dispatch_rs1_rdy` / `dispatch_rs2_rdy`  in  1  source value already valid.
- `dispatch_rs1_data` / `dispatch_rs2_data`  in  32  source value (used when rdy).
- `dispatch_rs1_tag` / `dispatch_rs2_tag`  in  TAG_W  producer tag (used when !rdy).
- `queue_full`  out  1  count == DEPTH; dispatch must not be asserted.
- `cdb_valid`  in  1  CDB broadcast valid.
- `cdb_tag`  in  TAG_W  CDB producer tag.
- `cdb_data`  in  32  CDB value.
- `issue_allow`  in  1  from CDB arbiter; issue slot available this cycle.
- `queue_en`  out  1  issue strobe to multiplier.
- `op1`, `op2`  out  32  operands to multiplier.
- `funct3`  out  3  variant to multiplier.
- `tag_in`  out  TAG_W  destination tag to multiplier.
- `tag_in_valid`  out  1  equals `queue_en`.
- `occupancy`  out  $clog2(DEPTH+1)  valid entry count (debug/perf).

## Operation

- Entry state: valid, funct3, rd_tag, and per source {rdy, tag, data}.
- The queue is collapsing: entry 0 is the oldest. On issue, entries above the issued index shift down one slot. A new dispatch is appended at index `occupancy` after any shift.
- Operand capture:
  - For each valid entry source with rdy=0, if `cdb_valid` and `cdb_tag` == source tag, latch `cdb_data` and set rdy=1.
  - A dispatching source with rdy=0 whose tag matches the same-cycle CDB captures `cdb_data` and is written as rdy=1 (bypass).
- Issue select: the lowest-index valid entry with both sources rdy, evaluated on registered state.
  - `queue_en` = `issue_allow` & a ready entry exists & !`flush`.
  - When `queue_en` is 1, `op1`/`op2`/`funct3`/`tag_in` come from the selected entry.
  - When `queue_en` is 0, `op1`, `op2`, `funct3` and `tag_in` are driven 0.
- The issued entry is removed at the clock edge ending the issue cycle.
- A CDB capture into an entry takes effect at the edge; that entry is issuable no earlier than the next cycle.
- `queue_full` is computed from registered count only. Dispatch while full is ignored, even if an issue occurs in the same cycle.
- Simultaneous dispatch and issue: count unchanged. The new entry lands at index `occupancy`−1 after the shift.
- Flush: all valid bits cleared and count set to 0 at the edge. Flush has priority over dispatch, issue and CDB capture. Ops already inside the multiplier are not cancelled by this block.
- Reset: all entries invalid, count 0, every output 0 (`queue_full`=0, `queue_en`=0, `tag_in_valid`=0, `occupancy`=0).

## Timing

- Dispatch with both rdy in cycle N → entry valid in N+1 → `queue_en` high in N+1 if `issue_allow`.
- Multiplier result and `tag_out_valid` then appear 3 cycles later (N+4).
- Dispatch waiting on a tag, CDB match in cycle M → issue earliest M+1.
- Throughput: one issue per cycle. Back-to-back issues are legal because the multiplier is fully pipelined and never stalls.
- `queue_en`, `op1`, `op2`, `funct3`, `tag_in` and `tag_in_valid` are combinational from registers and `issue_allow`/`flush`. There are no paths from the dispatch or CDB inputs to these outputs.
- `queue_full` and `occupancy` are registered-state outputs.

## Test plan

- Ready dispatch: dispatch rs1=7, rs2=6, funct3=0, rd_tag=5, both rdy, `issue_allow`=1 in cycle 0 → `queue_en`=1, op1=7, op2=6, `tag_in`=5 in cycle 1; multiplier `res`=42, `tag_out`=5 in cycle 4.
- CDB wakeup and bypass:
  - Dispatch rs1 waiting on tag 9, rs2=3 rdy; CDB tag 9 data 0x10 in cycle 3 → issue in cycle 4 with op1=0x10.
  - Repeat with the CDB match in the same cycle as dispatch → issue the following cycle.
- Age order: fill entries A (waiting), B (ready), C (ready); wake A → next issues in order B, then A, then C, according to readiness at each cycle. Verify B issues before C when both are ready.
- Full/backpressure: fill DEPTH=4 with `issue_allow`=0 → `queue_full`=1, `occupancy`=4. A further dispatch is dropped even with a same-cycle issue. Occupancy then reads 3.
- Flush: 3 valid entries, assert `flush` together with dispatch and CDB match → next cycle `occupancy`=0, `queue_en`=0. No later issue of the flushed tags.
- Reset mid-operation: assert `rst` with 2 entries pending and `issue_allow`=1 → all outputs 0 the next cycle, and queue empty.
